serial_sub_rtl: RTL
===================

Name: serial_sub_rtl

Overview:
Bit-serial, LSB-first subtractor computing d = a - b over WIDTH clock cycles using a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart of the team's add cells. It is used where area matters more than throughput. Operands arrive and results leave through valid/ready handshakes.

Parameters:
WIDTH, 8, operand and result width in bits (legal range >= 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair a, b is valid
in_ready  output  1  block accepts operands (high only in IDLE)
a  input  WIDTH  minuend, unsigned or two's complement
b  input  WIDTH  subtrahend
out_valid  output  1  d and bout are valid
out_ready  input  1  consumer accepts the result
d  output  WIDTH  difference a - b mod 2^WIDTH
bout  output  1  final borrow; 1 means unsigned a < b
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: asynchronous assert on rst_n low.
  - State goes to IDLE; shift registers, borrow and counter clear to 0.
  - Outputs during and after reset: d=0, bout=0, out_valid=0, busy=0, in_ready=1.
  - While rst_n is low, inputs are ignored.
- FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
- IDLE:
  - on in_valid & in_ready at edge E0: load a_sr=a and b_sr=b, borrow=0, cnt=0, then go to RUN.
  - If in_valid is low, stay in IDLE.
- RUN, at each edge E0+1+i for i = 0..WIDTH-1:
  - dbit = a_sr[0] ^ b_sr[0] ^ borrow
  - borrow <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow)
  - a_sr and b_sr shift right by one; d_sr shifts right with dbit inserted at the MSB.
  - cnt increments.
  - At the edge where cnt == WIDTH-1, go to DONE.
- Latency: out_valid rises in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after acceptance.
- DONE:
  - d = d_sr and bout = borrow, held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready, go to IDLE. d and bout keep their value until the next result; they are only meaningful while out_valid=1.
- Throughput: one operation per WIDTH+2 cycles minimum. There is no overlap: in_ready stays low in RUN and DONE, and in_valid in those states is ignored with no capture.
- Boundaries:
  - a == b gives d=0, bout=0.
  - a=0, b=2^WIDTH-1 gives d=1, bout=1.
  - Wrap-around is modulo 2^WIDTH.
- Reset mid-RUN or mid-DONE aborts the operation with no output produced. The next accepted operation is computed correctly.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined:
  - Adds output port ovf (1 bit, reset 0) giving two's-complement overflow.
  - ovf = (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]), using the operand MSBs captured at acceptance.
  - ovf is valid with out_valid.
- Undefined: the ovf port and its MSB capture registers do not exist. All other behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - function cnt_w(WIDTH) = $clog2(WIDTH) for the counter width.
- One sub-module, fs_rtl: a combinational 1-bit full subtractor.
  - Inputs x, y, bin; outputs dif = x^y^bin and bo.
  - Instantiated once.
- The FSM, counter and shift registers stay in serial_sub_rtl.

Test Plan:
- a=100 (0x64), b=37 (0x25), out_ready=1 -> d=0x3F, bout=0, out_valid exactly 8 cycles after the accept edge, held 1 cycle.
- a=0x05, b=0x0A -> d=0xFB, bout=1; then a=0x00, b=0xFF -> d=0x01, bout=1; then a=b=0xA5 -> d=0x00, bout=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> d and bout stable, in_ready=0, a new in_valid pulse is not captured; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: rst_n low at the 4th bit edge -> immediately out_valid=0, busy=0, in_ready=1, d=0; after release, a=0x10, b=0x01 -> d=0x0F, bout=0.
- Back-to-back: in_valid held high with 3 operand pairs -> each accepted only in IDLE; results in order; spacing >= WIDTH+2 cycles.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> d=0x7F, ovf=1; a=0x7F, b=0xFF -> d=0x80, ovf=1; a=0x05, b=0x03 -> ovf=0. Without the macro, the build has no ovf port and the same d/bout values.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/fs_rtl.sv
// Combinational 1-bit full subtractor: dif = x - y - bin, bo = borrow out.
module fs_rtl (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic dif,
    output logic bo
);

    assign dif = x ^ y ^ bin;
    assign bo  = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_rtl.sv
// Bit-serial LSB-first subtractor d = a - b with valid/ready handshakes.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_sub_rtl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_dbit;
    logic             w_bo;
    logic [WIDTH-1:0] w_d_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    fs_rtl u_fs (
        .x   (r_a_sr[0]),
        .y   (r_b_sr[0]),
        .bin (r_borrow),
        .dif (w_dbit),
        .bo  (w_bo)
    );

    assign w_d_next = {w_dbit, r_d_sr[WIDTH-1:1]};

    // Result registers are loaded only on the final bit so d/bout never
    // show partial sums and hold until the next completed operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_d_sr      <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_d         <= '0;
            r_bout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr     <= a;
                        r_b_sr     <= b;
                        r_borrow   <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb    <= a[WIDTH-1];
                        r_b_msb    <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_d_sr   <= w_d_next;
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_d         <= w_d_next;
                        r_bout      <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf       <= (r_a_msb ^ r_b_msb) & (w_dbit ^ r_a_msb);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign d         = r_d;
    assign bout      = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule
